// File: rtl/clk_enable_gen.sv
// Multi-channel tick / clock-enable generator with runtime-programmable divisors.
// Define CLKGEN_SYNC_EN to add the sync_in phase-align strobe.
module clk_enable_gen #(
   parameter int unsigned NUM_CH      = 5,
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned CH_W        = 3,
   parameter int unsigned DEFAULT_DIV = 5000
) (
   input  logic              CLK100Mhz,
   input  logic              reset,
`ifdef CLKGEN_SYNC_EN
   input  logic              sync_in,
`endif
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic              cfg_ack,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] DEF_CNT = (DEFAULT_DIV == 0) ? '0 : CNT_W'(DEFAULT_DIV - 1);

   logic [CNT_W-1:0]  div_act  [NUM_CH];
   logic [CNT_W-1:0]  div_pend [NUM_CH];
   logic [CNT_W-1:0]  cnt      [NUM_CH];
   logic [CNT_W-1:0]  eff_pend [NUM_CH];
   logic [CNT_W-1:0]  eff_load [NUM_CH];
   logic [NUM_CH-1:0] wr_hit;
   logic              cfg_valid;
   logic              sync_req;

   // eff_pend folds a same-cycle write into the reload value (bypass path)
   always_comb begin
`ifdef CLKGEN_SYNC_EN
      sync_req = sync_in;
`else
      sync_req = 1'b0;
`endif
      cfg_valid = (32'(cfg_ch) < NUM_CH);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wr_hit[i]   = cfg_we && (32'(cfg_ch) == i);
         eff_pend[i] = wr_hit[i] ? cfg_div : div_pend[i];
         eff_load[i] = (eff_pend[i] == '0) ? '0 : eff_pend[i] - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK100Mhz) begin
      if (reset) begin
         cfg_ack <= 1'b0;
         tick    <= '0;
         clk_out <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            div_act[i]  <= DEF_DIV;
            div_pend[i] <= DEF_DIV;
            cnt[i]      <= DEF_CNT;
         end
      end else begin
         cfg_ack <= cfg_we && cfg_valid;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            tick[i] <= 1'b0;
            if (wr_hit[i])
               div_pend[i] <= cfg_div;
            if (sync_req) begin
               // a zero divisor stops the channel and leaves clk_out frozen
               div_act[i] <= eff_pend[i];
               cnt[i]     <= eff_load[i];
               if (eff_pend[i] != '0)
                  clk_out[i] <= 1'b0;
            end else if (div_act[i] == '0) begin
               if (wr_hit[i]) begin
                  div_act[i] <= cfg_div;
                  cnt[i]     <= eff_load[i];
               end
            end else if (cnt[i] == '0) begin
               div_act[i] <= eff_pend[i];
               cnt[i]     <= eff_load[i];
               tick[i]    <= 1'b1;
               clk_out[i] <= ~clk_out[i];
            end else begin
               cnt[i] <= cnt[i] - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed self-checking bench for clk_enable_gen (DEFAULT_DIV=4, five channels).
// Cycle k is the state just after the k-th posedge following the reset edge.
module tb_clk_enable_gen;

   logic        CLK100Mhz = 1'b0;
   logic        reset     = 1'b1;
   logic        cfg_we    = 1'b0;
   logic [2:0]  cfg_ch    = '0;
   logic [25:0] cfg_div   = '0;
   logic        cfg_ack;
   logic [4:0]  tick;
   logic [4:0]  clk_out;
`ifdef CLKGEN_SYNC_EN
   logic        sync_in   = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   clk_enable_gen #(
      .NUM_CH(5),
      .CNT_W(26),
      .CH_W(3),
      .DEFAULT_DIV(4)
   ) dut (
      .CLK100Mhz(CLK100Mhz),
      .reset(reset),
`ifdef CLKGEN_SYNC_EN
      .sync_in(sync_in),
`endif
      .cfg_we(cfg_we),
      .cfg_ch(cfg_ch),
      .cfg_div(cfg_div),
      .cfg_ack(cfg_ack),
      .tick(tick),
      .clk_out(clk_out)
   );

   always #5 CLK100Mhz = ~CLK100Mhz;

   task automatic step();
      @(posedge CLK100Mhz);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      cfg_we = 1'b0;
      step();
      reset  = 1'b0;
   endtask

   task automatic write_cfg(input logic [2:0] ch, input logic [25:0] div);
      cfg_we  = 1'b1;
      cfg_ch  = ch;
      cfg_div = div;
      step();
      cfg_we  = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] exp_t, exp_c;
      do_reset();
      n_checks++; if (tick !== 5'h00) begin n_fail++; $display("FAIL reset_tick: got %b expected %b", tick, 5'h00); end
      n_checks++; if (clk_out !== 5'h00) begin n_fail++; $display("FAIL reset_clk: got %b expected %b", clk_out, 5'h00); end
      n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", cfg_ack); end
      for (int k = 1; k <= 12; k++) begin
         step();
         exp_t = (k % 4 == 0) ? 5'h1f : 5'h00;
         exp_c = ((k / 4) % 2 == 1) ? 5'h1f : 5'h00;
         n_checks++; if (tick !== exp_t) begin n_fail++; $display("FAIL free_tick k=%0d: got %b expected %b", k, tick, exp_t); end
         n_checks++; if (clk_out !== exp_c) begin n_fail++; $display("FAIL free_clk k=%0d: got %b expected %b", k, clk_out, exp_c); end
         n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL free_ack k=%0d: got %b expected 0", k, cfg_ack); end
      end
   endtask

   task automatic test_write_pending();
      do_reset();
      for (int k = 1; k <= 5; k++) step();
      write_cfg(3'd2, 26'd10);
      n_checks++; if (cfg_ack !== 1'b1) begin n_fail++; $display("FAIL pend_ack k=6: got %b expected 1", cfg_ack); end
      for (int k = 7; k <= 20; k++) begin
         step();
         n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL pend_ack k=%0d: got %b expected 0", k, cfg_ack); end
         n_checks++; if (tick[2] !== (k == 8 || k == 18)) begin n_fail++; $display("FAIL pend_tick2 k=%0d: got %b expected %b", k, tick[2], (k == 8 || k == 18)); end
         n_checks++; if (tick[0] !== (k % 4 == 0)) begin n_fail++; $display("FAIL pend_tick0 k=%0d: got %b expected %b", k, tick[0], (k % 4 == 0)); end
      end
   endtask

   task automatic test_stop();
      logic exp_t, exp_c;
      do_reset();
      step();
      write_cfg(3'd1, 26'd0);
      exp_c = 1'b0;
      for (int k = 3; k <= 20; k++) begin
         step();
         exp_t = (k == 4);
         if (exp_t) exp_c = ~exp_c;
         n_checks++; if (tick[1] !== exp_t) begin n_fail++; $display("FAIL stop_tick k=%0d: got %b expected %b", k, tick[1], exp_t); end
         n_checks++; if (clk_out[1] !== exp_c) begin n_fail++; $display("FAIL stop_clk k=%0d: got %b expected %b", k, clk_out[1], exp_c); end
      end
      write_cfg(3'd1, 26'd3);
      n_checks++; if (cfg_ack !== 1'b1) begin n_fail++; $display("FAIL restart_ack k=21: got %b expected 1", cfg_ack); end
      for (int k = 22; k <= 30; k++) begin
         step();
         exp_t = (k == 24 || k == 27 || k == 30);
         if (exp_t) exp_c = ~exp_c;
         n_checks++; if (tick[1] !== exp_t) begin n_fail++; $display("FAIL restart_tick k=%0d: got %b expected %b", k, tick[1], exp_t); end
         n_checks++; if (clk_out[1] !== exp_c) begin n_fail++; $display("FAIL restart_clk k=%0d: got %b expected %b", k, clk_out[1], exp_c); end
      end
   endtask

   task automatic test_bad_channel();
      logic [4:0] exp_t;
      do_reset();
      write_cfg(3'd7, 26'd2);
      n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL bad7_ack: got %b expected 0", cfg_ack); end
      write_cfg(3'd5, 26'd2);
      n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL bad5_ack: got %b expected 0", cfg_ack); end
      for (int k = 3; k <= 12; k++) begin
         step();
         exp_t = (k % 4 == 0) ? 5'h1f : 5'h00;
         n_checks++; if (tick !== exp_t) begin n_fail++; $display("FAIL bad_tick k=%0d: got %b expected %b", k, tick, exp_t); end
         n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL bad_ack k=%0d: got %b expected 0", k, cfg_ack); end
      end
   endtask

   task automatic test_bypass();
      do_reset();
      for (int k = 1; k <= 3; k++) step();
      write_cfg(3'd3, 26'd6);
      n_checks++; if (tick[3] !== 1'b1) begin n_fail++; $display("FAIL bypass_tick k=4: got %b expected 1", tick[3]); end
      n_checks++; if (cfg_ack !== 1'b1) begin n_fail++; $display("FAIL bypass_ack k=4: got %b expected 1", cfg_ack); end
      for (int k = 5; k <= 17; k++) begin
         step();
         n_checks++; if (tick[3] !== (k == 10 || k == 16)) begin n_fail++; $display("FAIL bypass_tick3 k=%0d: got %b expected %b", k, tick[3], (k == 10 || k == 16)); end
         n_checks++; if (tick[2] !== (k % 4 == 0)) begin n_fail++; $display("FAIL bypass_tick2 k=%0d: got %b expected %b", k, tick[2], (k % 4 == 0)); end
      end
   endtask

   task automatic test_div_one();
      do_reset();
      step();
      write_cfg(3'd0, 26'd1);
      for (int k = 3; k <= 10; k++) begin
         step();
         n_checks++; if (tick[0] !== (k >= 4)) begin n_fail++; $display("FAIL div1_tick k=%0d: got %b expected %b", k, tick[0], (k >= 4)); end
         n_checks++; if (clk_out[0] !== (k >= 4 && k % 2 == 0)) begin n_fail++; $display("FAIL div1_clk k=%0d: got %b expected %b", k, clk_out[0], (k >= 4 && k % 2 == 0)); end
      end
   endtask

   task automatic test_mid_reset();
      logic [4:0] exp_t, exp_c;
      do_reset();
      for (int k = 1; k <= 5; k++) step();
      reset   = 1'b1;
      cfg_we  = 1'b1;
      cfg_ch  = 3'd0;
      cfg_div = 26'd2;
      step();
      reset   = 1'b0;
      cfg_we  = 1'b0;
      n_checks++; if (tick !== 5'h00) begin n_fail++; $display("FAIL midrst_tick k=6: got %b expected %b", tick, 5'h00); end
      n_checks++; if (clk_out !== 5'h00) begin n_fail++; $display("FAIL midrst_clk k=6: got %b expected %b", clk_out, 5'h00); end
      n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_ack k=6: got %b expected 0", cfg_ack); end
      for (int k = 7; k <= 15; k++) begin
         step();
         exp_t = (k == 10 || k == 14) ? 5'h1f : 5'h00;
         exp_c = (k >= 10 && k < 14) ? 5'h1f : 5'h00;
         n_checks++; if (tick !== exp_t) begin n_fail++; $display("FAIL midrst_tick k=%0d: got %b expected %b", k, tick, exp_t); end
         n_checks++; if (clk_out !== exp_c) begin n_fail++; $display("FAIL midrst_clk k=%0d: got %b expected %b", k, clk_out, exp_c); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      write_cfg(3'd4, 26'd7);
      n_checks++; if (cfg_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack k=1: got %b expected 1", cfg_ack); end
      write_cfg(3'd4, 26'd2);
      n_checks++; if (cfg_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack k=2: got %b expected 1", cfg_ack); end
      for (int k = 3; k <= 9; k++) begin
         step();
         n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack k=%0d: got %b expected 0", k, cfg_ack); end
         n_checks++; if (tick[4] !== (k == 4 || k == 6 || k == 8)) begin n_fail++; $display("FAIL b2b_tick k=%0d: got %b expected %b", k, tick[4], (k == 4 || k == 6 || k == 8)); end
      end
   endtask

`ifdef CLKGEN_SYNC_EN
   task automatic test_sync();
      do_reset();
      write_cfg(3'd0, 26'd3);
      write_cfg(3'd1, 26'd5);
      for (int k = 3; k <= 16; k++) step();
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      n_checks++; if (tick[1:0] !== 2'b00) begin n_fail++; $display("FAIL sync_tick k=17: got %b expected 00", tick[1:0]); end
      n_checks++; if (clk_out[1:0] !== 2'b00) begin n_fail++; $display("FAIL sync_clk k=17: got %b expected 00", clk_out[1:0]); end
      for (int k = 18; k <= 23; k++) begin
         step();
         n_checks++; if (tick[0] !== (k == 20 || k == 23)) begin n_fail++; $display("FAIL sync_tick0 k=%0d: got %b expected %b", k, tick[0], (k == 20 || k == 23)); end
         n_checks++; if (tick[1] !== (k == 22)) begin n_fail++; $display("FAIL sync_tick1 k=%0d: got %b expected %b", k, tick[1], (k == 22)); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_pending();
      test_stop();
      test_bad_channel();
      test_bypass();
      test_div_one();
      test_mid_reset();
      test_back_to_back();
`ifdef CLKGEN_SYNC_EN
      test_sync();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
